// File: rtl/store_pkg.sv
// Shared encodings for the narrow store path: request sizes, FSM states,
// beat-count limit and small lane helpers used by the lane shifter.
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT1 = 2'b01,
    ST_BEAT2 = 2'b10
  } state_e;

  // A misaligned store never touches more than two words.
  localparam logic [1:0]  MAX_BEATS   = 2'd2;
  localparam logic [31:0] BEAT_STRIDE = 32'd4;

  // Byte enables of the store before placement at its lane offset.
  function automatic logic [3:0] size_base_be(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001;
      SIZE_HALF: be = 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Keeps only the low source bytes that belong to the store.
  function automatic logic [31:0] size_keep(input logic [1:0] size);
    logic [31:0] keep;
    case (size)
      SIZE_BYTE: keep = 32'h0000_00FF;
      SIZE_HALF: keep = 32'h0000_FFFF;
      SIZE_WORD: keep = 32'hFFFF_FFFF;
      default:   keep = 32'h0000_0000;
    endcase
    return keep;
  endfunction

  // Expands byte enables into a bit mask over the 32-bit data bus.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// Combinational byte-lane placement: positions the store data and enables
// across a two-word window so both beats of a split store fall out directly.
module lane_shifter
  import store_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata1_o,
  output logic [3:0]  be2_o,
  output logic [31:0] wdata2_o,
  output logic        split_o,
  output logic        ovf_o
);

  logic [31:0] data_m;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;

  // Shift the trimmed data and enables into an 8-lane window; the upper
  // half of the window is the spill into the following word.
  always_comb begin
    data_m  = data_i & size_keep(size_i);
    be_wide = {4'b0000, size_base_be(size_i)} << off_i;
    wd_wide = {32'h0, data_m} << {off_i, 3'b000};
  end

  assign be1_o    = be_wide[3:0];
  assign be2_o    = be_wide[7:4];
  assign wdata1_o = wd_wide[31:0]  & lane_mask(be_wide[3:0]);
  assign wdata2_o = wd_wide[63:32] & lane_mask(be_wide[7:4]);
  assign split_o  = |be_wide[7:4];

  // Overflow means the register value does not fit the narrowed width
  // as a sign-extended quantity.
  always_comb begin
    case (size_i)
      SIZE_BYTE: ovf_o = (data_i[31:8]  != {24{data_i[7]}});
      SIZE_HALF: ovf_o = (data_i[31:16] != {16{data_i[15]}});
      default:   ovf_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrow.sv
// Narrow/misaligned store sequencer: accepts one store request, then issues
// one or two word-aligned write beats with lane-placed data and enables.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a request; reserved sizes are dropped here
// ST_BEAT1 | first (or only) beat on the memory bus, held until accepted
// ST_BEAT2 | spill beat into the next word for a split store
module store_narrow
  import store_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_ovf,
  output logic        size_err
);

  state_e      state_q;
  logic        ready_q;
  logic        size_err_q;
  logic        valid_q;
  logic [31:0] mem_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        ovf_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [1:0]  beats_q;

  logic        accept;
  logic [31:0] sh_data;
  logic [1:0]  sh_size;
  logic [1:0]  sh_off;
  logic [3:0]  sh_be1;
  logic [3:0]  sh_be2;
  logic [31:0] sh_wdata1;
  logic [31:0] sh_wdata2;
  logic        sh_split;
  logic        sh_ovf;

  assign accept = req_valid & ready_q;

  // In IDLE the shifter looks at the live request (first beat is loaded on
  // accept); afterwards it looks at the captured request for the spill beat.
  always_comb begin
    if (state_q == ST_IDLE) begin
      sh_data = req_data;
      sh_size = req_size;
      sh_off  = req_addr[1:0];
    end else begin
      sh_data = data_q;
      sh_size = size_q;
      sh_off  = off_q;
    end
  end

  lane_shifter u_lane_shifter (
    .data_i   (sh_data),
    .size_i   (sh_size),
    .off_i    (sh_off),
    .be1_o    (sh_be1),
    .wdata1_o (sh_wdata1),
    .be2_o    (sh_be2),
    .wdata2_o (sh_wdata2),
    .split_o  (sh_split),
    .ovf_o    (sh_ovf)
  );

  // Store FSM with registered request and memory-bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      size_err_q <= 1'b0;
      valid_q    <= 1'b0;
      mem_addr_q <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'b0000;
      ovf_q      <= 1'b0;
      addr_q     <= 30'h0;
      data_q     <= 32'h0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      beats_q    <= 2'd0;
    end else begin
      size_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // ready_q is low only for the first cycle out of reset.
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          if (accept) begin
            if (req_size == SIZE_RSVD) begin
              size_err_q <= 1'b1;
            end else begin
              state_q    <= ST_BEAT1;
              ready_q    <= 1'b0;
              valid_q    <= 1'b1;
              addr_q     <= req_addr[31:2];
              data_q     <= req_data;
              size_q     <= req_size;
              off_q      <= req_addr[1:0];
              mem_addr_q <= {req_addr[31:2], 2'b00};
              wdata_q    <= sh_wdata1;
              be_q       <= sh_be1;
              ovf_q      <= sh_ovf;
              beats_q    <= sh_split ? MAX_BEATS : 2'd1;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            if (beats_q == MAX_BEATS) begin
              state_q    <= ST_BEAT2;
              mem_addr_q <= {addr_q, 2'b00} + BEAT_STRIDE;
              wdata_q    <= sh_wdata2;
              be_q       <= sh_be2;
            end else begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
        ST_BEAT2: begin
          if (mem_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign size_err  = size_err_q;
  assign mem_valid = valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign mem_ovf   = ovf_q;

endmodule

// File: tb/tb_store_narrow.sv
// Self-checking bench for store_narrow: directed cases for the notable
// stores plus a randomized run checked against a byte-level memory model.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ovf;
  logic        size_err;

  int total = 0;
  int bad = 0;

  // observed transfer
  logic [31:0] cap_addr [4];
  logic [31:0] cap_wd   [4];
  logic [3:0]  cap_be   [4];
  logic        cap_ovf  [4];
  int          cap_n;
  int          first_valid;
  int          err_cycles;
  int          stable_bad;
  bit          timed_out;
  bit          ready_dropped;

  // reference model result
  logic [31:0] exp_addr [2];
  logic [31:0] exp_wd   [2];
  logic [3:0]  exp_be   [2];
  int          exp_n;
  logic        exp_ovf;

  always #5 clk = ~clk;

  store_narrow dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ovf   (mem_ovf),
    .size_err  (size_err)
  );

  // Byte-level model: each stored byte k goes to address a+k; bytes are
  // grouped by the word they land in.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int nbytes;
    int idx;
    int lane;
    int sd;
    logic [31:0] ba;
    exp_n = 0;
    exp_addr[0] = a & 32'hFFFF_FFFC;
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_be[0] = 4'b0000;
    exp_be[1] = 4'b0000;
    exp_wd[0] = 32'h0;
    exp_wd[1] = 32'h0;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    for (int k = 0; k < nbytes; k++) begin
      ba = a + k;
      idx = ((ba & 32'hFFFF_FFFC) == exp_addr[0]) ? 0 : 1;
      lane = int'(ba % 4);
      exp_be[idx][lane] = 1'b1;
      exp_wd[idx][lane*8 +: 8] = d[k*8 +: 8];
      if (idx + 1 > exp_n) exp_n = idx + 1;
    end
    sd = $signed(d);
    if (sz == 2'd0)      exp_ovf = (sd > 127) || (sd < -128);
    else if (sz == 2'd1) exp_ovf = (sd > 32767) || (sd < -32768);
    else                 exp_ovf = 1'b0;
  endtask

  // Issues one request and records every beat; stall >= 0 holds mem_ready
  // low that many cycles per beat, stall < 0 picks a random stall per beat.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int stall);
    int cyc;
    int wait_cyc;
    int st_left;
    bit prev_stall;
    logic [31:0] h_addr;
    logic [31:0] h_wd;
    logic [3:0]  h_be;
    logic        h_ovf;
    cap_n = 0;
    first_valid = -1;
    err_cycles = 0;
    stable_bad = 0;
    timed_out = 0;
    ready_dropped = 0;
    h_addr = 32'h0;
    h_wd = 32'h0;
    h_be = 4'h0;
    h_ovf = 1'b0;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!req_ready) begin
      timed_out = 1;
      return;
    end
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    req_size = sz;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom;
    req_data = $urandom;
    req_size = 2'($urandom_range(0, 3));
    cyc = 1;
    prev_stall = 0;
    st_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    while (1) begin
      if (size_err) err_cycles++;
      if (!req_ready) ready_dropped = 1;
      if (mem_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall && (mem_addr !== h_addr || mem_wdata !== h_wd ||
                           mem_be !== h_be || mem_ovf !== h_ovf))
          stable_bad++;
        h_addr = mem_addr;
        h_wd = mem_wdata;
        h_be = mem_be;
        h_ovf = mem_ovf;
        if (st_left > 0) begin
          mem_ready = 1'b0;
          st_left--;
          prev_stall = 1;
        end else begin
          mem_ready = 1'b1;
          prev_stall = 0;
          if (cap_n < 4) begin
            cap_addr[cap_n] = mem_addr;
            cap_wd[cap_n] = mem_wdata;
            cap_be[cap_n] = mem_be;
            cap_ovf[cap_n] = mem_ovf;
          end
          cap_n++;
          st_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end
      end else begin
        mem_ready = 1'b0;
        prev_stall = 0;
      end
      if (cyc >= 2 && req_ready && !mem_valid) break;
      if (cyc >= 60) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_addr = $urandom;
    req_data = $urandom;
    #2;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    total++; if (size_err !== 1'b0) begin bad++; $display("FAIL rst_size_err: got %b want 0", size_err); end
    total++; if ({mem_addr, mem_wdata, mem_be, mem_ovf} !== 69'h0)
      begin bad++; $display("FAIL rst_mem_bus: got addr=%h wd=%h be=%b ovf=%b want all zero", mem_addr, mem_wdata, mem_be, mem_ovf); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid: got %b want 0", mem_valid); end
  endtask

  task automatic test_word_aligned();
    run_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0);
    total++; if (timed_out) begin bad++; $display("FAIL word_timeout: got timeout want completion"); end
    total++; if (cap_n !== 1) begin bad++; $display("FAIL word_beats: got %0d want 1", cap_n); end
    total++; if (first_valid !== 1) begin bad++; $display("FAIL word_latency: got %0d want 1", first_valid); end
    total++; if (cap_addr[0] !== 32'h100 || cap_be[0] !== 4'b1111 || cap_wd[0] !== 32'hDEAD_BEEF || cap_ovf[0] !== 1'b0)
      begin bad++; $display("FAIL word_beat: got %h/%b/%h/%b want 00000100/1111/deadbeef/0", cap_addr[0], cap_be[0], cap_wd[0], cap_ovf[0]); end
  endtask

  task automatic test_byte();
    run_store(32'h0000_0203, 32'h0000_0180, 2'b00, 1);
    total++; if (cap_n !== 1) begin bad++; $display("FAIL byte_beats: got %0d want 1", cap_n); end
    total++; if (cap_addr[0] !== 32'h200 || cap_be[0] !== 4'b1000 || cap_wd[0] !== 32'h8000_0000 || cap_ovf[0] !== 1'b1)
      begin bad++; $display("FAIL byte_beat: got %h/%b/%h/%b want 00000200/1000/80000000/1", cap_addr[0], cap_be[0], cap_wd[0], cap_ovf[0]); end
  endtask

  task automatic test_split_half();
    run_store(32'h0000_0107, 32'h0000_A55A, 2'b01, 0);
    total++; if (cap_n !== 2) begin bad++; $display("FAIL half_beats: got %0d want 2", cap_n); end
    total++; if (cap_addr[0] !== 32'h104 || cap_be[0] !== 4'b1000 || cap_wd[0] !== 32'h5A00_0000)
      begin bad++; $display("FAIL half_beat1: got %h/%b/%h want 00000104/1000/5a000000", cap_addr[0], cap_be[0], cap_wd[0]); end
    total++; if (cap_addr[1] !== 32'h108 || cap_be[1] !== 4'b0001 || cap_wd[1] !== 32'h0000_00A5)
      begin bad++; $display("FAIL half_beat2: got %h/%b/%h want 00000108/0001/000000a5", cap_addr[1], cap_be[1], cap_wd[1]); end
    total++; if (cap_ovf[0] !== 1'b1 || cap_ovf[1] !== 1'b1)
      begin bad++; $display("FAIL half_ovf: got %b%b want 11", cap_ovf[0], cap_ovf[1]); end
  endtask

  task automatic test_split_word_wrap();
    run_store(32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 3);
    total++; if (cap_n !== 2) begin bad++; $display("FAIL wrap_beats: got %0d want 2", cap_n); end
    total++; if (cap_addr[0] !== 32'hFFFF_FFFC || cap_be[0] !== 4'b1100 || cap_wd[0] !== 32'h3344_0000)
      begin bad++; $display("FAIL wrap_beat1: got %h/%b/%h want fffffffc/1100/33440000", cap_addr[0], cap_be[0], cap_wd[0]); end
    total++; if (cap_addr[1] !== 32'h0 || cap_be[1] !== 4'b0011 || cap_wd[1] !== 32'h0000_1122)
      begin bad++; $display("FAIL wrap_beat2: got %h/%b/%h want 00000000/0011/00001122", cap_addr[1], cap_be[1], cap_wd[1]); end
    total++; if (stable_bad !== 0) begin bad++; $display("FAIL wrap_stall_stable: got %0d changes want 0", stable_bad); end
  endtask

  task automatic test_reserved();
    run_store(32'h0000_0040, 32'h1234_5678, 2'b11, 0);
    total++; if (cap_n !== 0) begin bad++; $display("FAIL rsvd_beats: got %0d want 0", cap_n); end
    total++; if (err_cycles !== 1) begin bad++; $display("FAIL rsvd_size_err: got %0d cycles want 1", err_cycles); end
    total++; if (ready_dropped !== 1'b0) begin bad++; $display("FAIL rsvd_ready: got dropped=%b want 0", ready_dropped); end
  endtask

  task automatic test_reset_mid_split();
    int seen;
    int wait_cyc;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    req_valid = 1'b1;
    req_addr = 32'h0000_1001;
    req_data = $urandom;
    req_size = 2'b10;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1004)
      begin bad++; $display("FAIL rmid_in_beat2: got valid=%b addr=%h want 1/00001004", mem_valid, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_valid !== 1'b0 || req_ready !== 1'b0 || mem_be !== 4'b0000)
      begin bad++; $display("FAIL rmid_async: got valid=%b ready=%b be=%b want 0/0/0000", mem_valid, req_ready, mem_be); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    seen = 0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 6; i++) begin
      if (mem_valid) seen++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_stale_beat: got %0d beats want 0", seen); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    int nb;
    for (int it = 0; it < 80; it++) begin
      a = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: d = 32'($urandom_range(0, 255));
        1: d = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        2: d = {{16{1'b1}}, 16'($urandom)};
        default: d = $urandom;
      endcase
      sz = 2'($urandom_range(0, 3));
      model(a, d, sz);
      run_store(a, d, sz, -1);
      total++; if (timed_out) begin bad++; $display("FAIL rnd_timeout[%0d]: got timeout want completion", it); end
      total++; if (cap_n !== exp_n) begin bad++; $display("FAIL rnd_beats[%0d]: got %0d want %0d (a=%h sz=%0d)", it, cap_n, exp_n, a, sz); end
      total++; if (err_cycles !== ((sz == 2'b11) ? 1 : 0))
        begin bad++; $display("FAIL rnd_size_err[%0d]: got %0d want %0d", it, err_cycles, (sz == 2'b11) ? 1 : 0); end
      total++; if (stable_bad !== 0) begin bad++; $display("FAIL rnd_stable[%0d]: got %0d want 0", it, stable_bad); end
      if (exp_n > 0) begin
        total++; if (first_valid !== 1) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want 1", it, first_valid); end
      end
      nb = (cap_n < exp_n) ? cap_n : exp_n;
      for (int b = 0; b < nb; b++) begin
        total++;
        if (cap_addr[b] !== exp_addr[b] || cap_be[b] !== exp_be[b] ||
            cap_wd[b] !== exp_wd[b] || cap_ovf[b] !== exp_ovf) begin
          bad++;
          $display("FAIL rnd_beat[%0d.%0d]: got %h/%b/%h/%b want %h/%b/%h/%b (a=%h d=%h sz=%0d)",
                   it, b, cap_addr[b], cap_be[b], cap_wd[b], cap_ovf[b],
                   exp_addr[b], exp_be[b], exp_wd[b], exp_ovf, a, d, sz);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_aligned();
    test_byte();
    test_split_half();
    test_split_word_wrap();
    test_reserved();
    test_reset_mid_split();
    test_random();
    test_word_aligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 SHALL have exactly one clock and one reset: CLK input 1, rising-edge clock; RST input 1, asynchronous, active-low reset.
REQ-002 SHALL expose req_valid input 1: store request valid.
REQ-003 SHALL expose req_ready output 1: block can accept a request.
REQ-004 SHALL expose req_addr input 32: byte address.
REQ-005 SHALL expose req_data input 32: register source data; the low bytes are the ones stored.
REQ-006 SHALL expose req_size input 2: store size, encoded 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL expose mem_valid output 1: memory write beat valid.
REQ-008 SHALL expose mem_ready input 1: memory accepts the beat.
REQ-009 SHALL expose mem_addr output 32: word-aligned beat address, with bits [1:0] always 00.
REQ-010 SHALL expose mem_wdata output 32: lane-placed write data.
REQ-011 SHALL expose mem_be output 4: byte enables; bit i enables lane i, i.e. bits [8i+7:8i].
REQ-012 SHALL expose mem_ovf output 1: narrowing-overflow flag, valid with each beat.
REQ-013 SHALL expose size_err output 1: one-cycle pulse when a reserved-size request is dropped.

Function
REQ-014 SHALL implement the FSM states IDLE, BEAT1 and BEAT2, where o = req_addr[1:0] captured at accept.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a CLK edge.
REQ-016 SHALL register addr, data, size and o on accept; the input bus is don't-care afterwards.
REQ-017 SHALL, on accept of size 11, stay in IDLE, generate no beat, and pulse size_err in the following cycle.
REQ-018 SHALL, on accept of a valid size, go to BEAT1 with mem_valid=1 in the next cycle (latency 1 cycle).
REQ-019 SHALL hold mem_addr, mem_wdata, mem_be and mem_ovf stable while mem_valid=1 and mem_ready=0.
REQ-020 SHALL treat a beat as complete on a CLK edge with mem_valid and mem_ready both 1.
REQ-021 SHALL, on a byte store, emit one beat: be = 0001<<o; wdata lane o = data[7:0].
REQ-022 SHALL, on a halfword store with o<=2, emit one beat: be = 0011<<o; wdata = data[15:0]<<8o.
REQ-023 SHALL, on a halfword store with o=3, emit two beats: BEAT1 be=1000, lane3 = data[7:0]; BEAT2 be=0001, lane0 = data[15:8].
REQ-024 SHALL, on a word store with o=0, emit one beat: be=1111, wdata=data.
REQ-025 SHALL, on a word store with o!=0, emit two beats: BEAT1 be=(1111<<o)[3:0], wdata=data<<8o; BEAT2 be=1111>>(4-o), wdata=data>>8(4-o).
REQ-026 SHALL drive zero on every unenabled mem_wdata lane.
REQ-027 SHALL set BEAT1 mem_addr = {addr[31:2],00} and BEAT2 mem_addr = BEAT1 mem_addr + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-028 SHALL, on completion of a one-beat transfer, go BEAT1->IDLE; on completion of BEAT1 of a split transfer, go BEAT1->BEAT2; on completion of BEAT2, go BEAT2->IDLE.
REQ-029 SHALL deassert mem_valid in IDLE; req_ready rises in the cycle after the final beat completes.
REQ-030 SHALL compute mem_ovf as: byte -> data[31:8] not all equal to data[7]; half -> data[31:16] not all equal to data[15]; word -> 0. The value is identical on both beats.
REQ-031 SHALL keep the store unaffected by mem_ovf; the flag is informational only.

Reset
REQ-032 SHALL, while RST=0, immediately force state=IDLE, mem_valid=0, req_ready=0, size_err=0, mem_addr=0, mem_wdata=0, mem_be=0000 and mem_ovf=0.
REQ-033 SHALL set req_ready=1 in the first cycle after RST deasserts.
REQ-034 SHALL abandon any in-flight transfer on reset assertion, including a split transfer between BEAT1 and BEAT2; no further beats are issued and the transfer is not resumed.

Structure
REQ-035 SHALL place the size encodings, the FSM state encoding and the beat-count constant in the shared package store_pkg.
REQ-036 SHALL place byte-lane placement (shift, enable and mask generation) in one combinational sub-module lane_shifter; the FSM and registers stay in store_narrow.

Verification
REQ-037 SHALL cover an aligned word store: addr=0x100, data=0xDEADBEEF, size=10, mem_ready=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF, ovf 0.
REQ-038 SHALL cover a byte store: addr=0x203, data=0x00000180, size=00 -> be 1000, wdata 0x80000000, ovf 1.
REQ-039 SHALL cover a split halfword store: addr=0x107, data=0x0000A55A, size=01 -> beat 1: 0x104, be 1000, wdata 0x5A000000; beat 2: 0x108, be 0001, wdata 0x000000A5.
REQ-040 SHALL cover a split word store with wrap and backpressure: addr=0xFFFFFFFE, data=0x11223344, mem_ready low for 3 cycles on each beat -> beat 1: 0xFFFFFFFC, be 1100, wdata 0x33440000, held stable while stalled; beat 2: 0x00000000, be 0011, wdata 0x00001122.
REQ-041 SHALL cover a reserved size: size=11 accepted -> no mem_valid, size_err high exactly one cycle, req_ready stays 1.
REQ-042 SHALL cover reset mid-split: RST low during BEAT2 -> mem_valid=0 at once; after release, req_ready=1 and no stale beat is issued.
